// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: FSM state
// encodings, the buffered entry layout and a PC alignment helper.
package fetch_queue_pkg;

    // Fetch FSM state encodings (2-bit, legacy-compatible constants)
    localparam logic [1:0] FQ_IDLE  = 2'd0;
    localparam logic [1:0] FQ_REQ   = 2'd1;
    localparam logic [1:0] FQ_WAIT  = 2'd2;
    localparam logic [1:0] FQ_DRAIN = 2'd3;

    // One buffered fetch: instruction word in the upper half, its PC below
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fq_entry_t;

    // Fetch addresses are always word aligned; low bits of a target are dropped
    function automatic logic [31:0] fq_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_fifo_sync.sv
// Small synchronous FIFO with a synchronous clear and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fifo_sync #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer and occupancy update; clear wins over any push or pop
    always_comb begin
        do_push  = push && (count_q != DEPTH_C);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches with at most
// one request outstanding, buffers returned words with their PC and hands
// them to the core over valid/ready. Redirects flush the buffer and discard
// any response belonging to the old stream.
// Optional feature macro: FETCHQ_BYPASS_EN (response forwarded to the
// outputs in the same cycle when the buffer is empty).
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    // state    | meaning
    // FQ_IDLE  | no request; waits for a free buffer slot
    // FQ_REQ   | mem_req high, address held until mem_gnt
    // FQ_WAIT  | granted, response will be buffered
    // FQ_DRAIN | granted, response belongs to a flushed stream and is dropped

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] addr_q, addr_d;
    logic        stale_q, stale_d;

    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_empty;
    logic        fifo_full;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic        slot_left;
    logic        resp_take;
    logic        bypass_vld;
    fq_entry_t   wr_entry;
    fq_entry_t   head;

    fifo_sync #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (redirect),
        .push  (fifo_push),
        .wdata (wr_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .count (count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Buffer push/pop decisions; a redirect suppresses both
    always_comb begin
        resp_take = (state_q == FQ_WAIT) && mem_rvalid && !redirect;
`ifdef FETCHQ_BYPASS_EN
        bypass_vld = resp_take && fifo_empty;
`else
        bypass_vld = 1'b0;
`endif
        fifo_pop    = !redirect && !fifo_empty && out_ready;
        fifo_push   = resp_take && !(bypass_vld && out_ready) && !fifo_full;
        wr_entry    = '{instr: mem_rdata, pc: req_pc_q};
        count_after = count + CW'(fifo_push) - CW'(fifo_pop);
        slot_left   = (count_after < DEPTH_C);
    end

    // Fetch FSM and PC bookkeeping
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        stale_d    = 1'b0;
        case (state_q)
            FQ_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = fq_align(redirect_pc);
                    state_d    = FQ_REQ;
                end else if (count < DEPTH_C) begin
                    state_d = FQ_REQ;
                end
            end
            FQ_REQ: begin
                // The request is never withdrawn; a redirect only marks it stale
                if (mem_gnt) begin
                    if (stale_q || redirect) begin
                        state_d = FQ_DRAIN;
                    end else begin
                        req_pc_d   = addr_q;
                        fetch_pc_d = addr_q + 32'd4;
                        state_d    = FQ_WAIT;
                    end
                end else begin
                    stale_d = stale_q || redirect;
                end
                if (redirect) fetch_pc_d = fq_align(redirect_pc);
            end
            FQ_WAIT: begin
                if (redirect) begin
                    fetch_pc_d = fq_align(redirect_pc);
                    state_d    = mem_rvalid ? FQ_REQ : FQ_DRAIN;
                end else if (mem_rvalid) begin
                    state_d = slot_left ? FQ_REQ : FQ_IDLE;
                end
            end
            FQ_DRAIN: begin
                if (redirect) fetch_pc_d = fq_align(redirect_pc);
                if (mem_rvalid) state_d = FQ_REQ;
            end
            default: state_d = FQ_IDLE;
        endcase
        // Latch the request address on entry to REQ so it is stable until grant
        addr_d = ((state_d == FQ_REQ) && (state_q != FQ_REQ)) ? fetch_pc_d : addr_q;
    end

    // FSM and PC registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= FQ_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            addr_q     <= RESET_PC;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            addr_q     <= addr_d;
            stale_q    <= stale_d;
        end
    end

    // Core-facing outputs; zero whenever nothing valid is presented
    always_comb begin
        out_valid = 1'b0;
        out_instr = '0;
        out_pc    = '0;
        if (!fifo_empty) begin
            out_valid = 1'b1;
            out_instr = head.instr;
            out_pc    = head.pc;
        end else if (bypass_vld) begin
            out_valid = 1'b1;
            out_instr = mem_rdata;
            out_pc    = req_pc_q;
        end
    end

    assign mem_req  = (state_q == FQ_REQ);
    assign mem_addr = addr_q;

endmodule
